// File: rtl/bram_dma_pkg.sv
// Purpose : shared op codes, FSM state encoding and RAM depth helper for the BRAM DMA engine.
// Latency : n/a (declarations only).
// Backpressure : n/a.
// Ports   : none.
package bram_dma_pkg;

  localparam logic OP_COPY = 1'b0;
  localparam logic OP_FILL = 1'b1;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_CHECK    = 3'd1;
  localparam state_t S_RD_ISSUE = 3'd2;
  localparam state_t S_RD_WAIT  = 3'd3;
  localparam state_t S_WR       = 3'd4;
  localparam state_t S_FILL_WR  = 3'd5;
  localparam state_t S_FIN      = 3'd6;

  localparam int WORDS_PER_BLOCK = 256;

  // RAM depth in words for a given number of 256-word blocks.
  function automatic int dma_depth(input int blocks);
    return blocks * WORDS_PER_BLOCK;
  endfunction

endpackage

// File: rtl/bram_dma_addr_gen.sv
// Purpose : loadable up/down word-address counter (one per source / destination stream).
// Latency : load or step visible on o_addr the cycle after the request.
// Backpressure : none; caller only asserts i_step when a transfer actually happened.
// Ports   : i_clk, i_rst (async, active-high), i_load/i_load_val (start address),
//           i_step/i_down (advance by one, downward when i_down), o_addr (current address).
module bram_dma_addr_gen
  import bram_dma_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_val,
  input  logic              i_step,
  input  logic              i_down,
  output logic [ADDR_W-1:0] o_addr
);

  logic [ADDR_W-1:0] r_addr;

  // Load wins over step so a new command always starts from a clean address.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr <= '0;
    end else if (i_load) begin
      r_addr <= i_load_val;
    end else if (i_step) begin
      r_addr <= i_down ? (r_addr - ADDR_W'(1)) : (r_addr + ADDR_W'(1));
    end
  end

  assign o_addr = r_addr;

endmodule

// File: rtl/bram_dma_engine.sv
// Purpose : single-command BRAM bus master performing memmove-safe COPY or FILL over a word range.
// Latency : CHECK 1 cycle; COPY 2+READ_LAT cycles/word, FILL 1 cycle/word; done one cycle after last write.
// Backpressure : writes stall while i_ram_save_rdy=0, reads stall while i_ram_read_rdy=0; cmd only taken when idle.
// Ports   : i_cmd_* / o_cmd_ready command handshake; o_busy, o_done (pulse), o_err (sticky range error);
//           o_ram_addr/o_ram_din/o_ram_we/o_ram_start_read RAM drive; i_ram_dout/i_ram_read_rdy/i_ram_save_rdy RAM status.
module bram_dma_engine
  import bram_dma_pkg::*;
#(
  parameter int BLOCKS   = 14,
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 32,
  parameter int LEN_W    = 12,
  parameter int READ_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_op,
  input  logic [ADDR_W-1:0] i_cmd_src,
  input  logic [ADDR_W-1:0] i_cmd_dst,
  input  logic [LEN_W-1:0]  i_cmd_len,
  input  logic [DATA_W-1:0] i_cmd_fill,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_din,
  output logic              o_ram_we,
  output logic              o_ram_start_read,
  input  logic [DATA_W-1:0] i_ram_dout,
  input  logic              i_ram_read_rdy,
  input  logic              i_ram_save_rdy
);

  localparam int DEPTH = dma_depth(BLOCKS);
  // One extra bit so start+len cannot wrap past the top of the address space.
  localparam int SUM_W = ADDR_W + 1;
  localparam int LAT_W = 5;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LAT - 1);

  state_t            r_state;
  logic              r_op;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_rem;
  logic [DATA_W-1:0] r_fill;
  logic [DATA_W-1:0] r_data;
  logic              r_err;
  logic              r_down;
  logic [LAT_W-1:0]  r_lat;

  logic [SUM_W-1:0]  w_src_end;
  logic [SUM_W-1:0]  w_dst_end;
  logic [SUM_W-1:0]  w_src_last;
  logic [SUM_W-1:0]  w_dst_last;
  logic              w_range_err;
  logic              w_overlap;
  logic [ADDR_W-1:0] w_src_load;
  logic [ADDR_W-1:0] w_dst_load;
  logic [ADDR_W-1:0] w_src_addr;
  logic [ADDR_W-1:0] w_dst_addr;
  logic              w_wr_state;
  logic              w_write;
  logic              w_lat_ok;

  // ---------------- range / overlap check (evaluated in CHECK) ----------------
  assign w_src_end   = {1'b0, r_src} + SUM_W'(r_len);
  assign w_dst_end   = {1'b0, r_dst} + SUM_W'(r_len);
  assign w_src_last  = w_src_end - SUM_W'(1);
  assign w_dst_last  = w_dst_end - SUM_W'(1);

  assign w_range_err = (w_dst_end > SUM_W'(DEPTH)) ||
                       ((r_op == OP_COPY) && (w_src_end > SUM_W'(DEPTH)));

  // Destination starts inside the source window above src: copying upward
  // would overwrite source words before they are read, so walk top-down.
  assign w_overlap   = (r_op == OP_COPY) && (r_dst > r_src) &&
                       ({1'b0, r_dst} < w_src_end);

  assign w_src_load  = w_overlap ? w_src_last[ADDR_W-1:0] : r_src;
  assign w_dst_load  = w_overlap ? w_dst_last[ADDR_W-1:0] : r_dst;

  // ---------------- datapath strobes ----------------
  assign w_wr_state  = (r_state == S_WR) || (r_state == S_FILL_WR);
  assign w_write     = w_wr_state && i_ram_save_rdy;
  assign w_lat_ok    = (r_lat >= LAT_LAST);

  bram_dma_addr_gen #(.ADDR_W(ADDR_W)) u_src_gen (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (r_state == S_CHECK),
    .i_load_val (w_src_load),
    .i_step     ((r_state == S_WR) && i_ram_save_rdy),
    .i_down     (r_down),
    .o_addr     (w_src_addr)
  );

  bram_dma_addr_gen #(.ADDR_W(ADDR_W)) u_dst_gen (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (r_state == S_CHECK),
    .i_load_val (w_dst_load),
    .i_step     (w_write),
    .i_down     (r_down),
    .o_addr     (w_dst_addr)
  );

  // ---------------- FSM, length counter, capture register ----------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_op    <= OP_COPY;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_rem   <= '0;
      r_fill  <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_down  <= 1'b0;
      r_lat   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            r_op    <= i_cmd_op;
            r_src   <= i_cmd_src;
            r_dst   <= i_cmd_dst;
            r_len   <= i_cmd_len;
            r_rem   <= i_cmd_len;
            r_fill  <= i_cmd_fill;
            r_err   <= 1'b0;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (r_len == '0) begin
            r_state <= S_FIN;
          end else if (w_range_err) begin
            r_err   <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_down  <= w_overlap;
            r_state <= (r_op == OP_COPY) ? S_RD_ISSUE : S_FILL_WR;
          end
        end
        S_RD_ISSUE: begin
          r_lat   <= '0;
          r_state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (w_lat_ok) begin
            if (i_ram_read_rdy) begin
              r_data  <= i_ram_dout;
              r_state <= S_WR;
            end
          end else begin
            r_lat <= r_lat + LAT_W'(1);
          end
        end
        S_WR: begin
          if (i_ram_save_rdy) begin
            r_rem   <= r_rem - LEN_W'(1);
            r_state <= (r_rem == LEN_W'(1)) ? S_FIN : S_RD_ISSUE;
          end
        end
        S_FILL_WR: begin
          if (i_ram_save_rdy) begin
            r_rem <= r_rem - LEN_W'(1);
            if (r_rem == LEN_W'(1)) begin
              r_state <= S_FIN;
            end
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------- outputs (decoded from state so reset clears them at once) ----------------
  always_comb begin
    o_ram_addr = '0;
    o_ram_din  = '0;
    case (r_state)
      S_RD_ISSUE, S_RD_WAIT: o_ram_addr = w_src_addr;
      S_WR: begin
        o_ram_addr = w_dst_addr;
        o_ram_din  = r_data;
      end
      S_FILL_WR: begin
        o_ram_addr = w_dst_addr;
        o_ram_din  = r_fill;
      end
      default: begin
        o_ram_addr = '0;
        o_ram_din  = '0;
      end
    endcase
  end

  assign o_cmd_ready      = (r_state == S_IDLE);
  assign o_busy           = (r_state != S_IDLE);
  assign o_done           = (r_state == S_FIN);
  assign o_err            = r_err;
  assign o_ram_we         = w_write;
  assign o_ram_start_read = (r_state == S_RD_ISSUE);

endmodule

// File: tb/tb_bram_dma_engine.sv
// Purpose : scoreboard bench for bram_dma_engine; directed commands push expected writes/done status,
//           a negedge monitor pops and compares whenever the DUT writes or pulses done.
// Latency : n/a.
// Backpressure : bench drives i_ram_save_rdy low for a window during one FILL.
module tb_bram_dma_engine;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [14:0] cmd_src;
  logic [14:0] cmd_dst;
  logic [11:0] cmd_len;
  logic [31:0] cmd_fill;
  logic        busy;
  logic        done;
  logic        err;
  logic [14:0] ram_addr;
  logic [31:0] ram_din;
  logic        ram_we;
  logic        ram_start_read;
  logic [31:0] ram_dout;
  logic        ram_read_rdy;
  logic        ram_save_rdy;

  bram_dma_engine dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_cmd_valid      (cmd_valid),
    .o_cmd_ready      (cmd_ready),
    .i_cmd_op         (cmd_op),
    .i_cmd_src        (cmd_src),
    .i_cmd_dst        (cmd_dst),
    .i_cmd_len        (cmd_len),
    .i_cmd_fill       (cmd_fill),
    .o_busy           (busy),
    .o_done           (done),
    .o_err            (err),
    .o_ram_addr       (ram_addr),
    .o_ram_din        (ram_din),
    .o_ram_we         (ram_we),
    .o_ram_start_read (ram_start_read),
    .i_ram_dout       (ram_dout),
    .i_ram_read_rdy   (ram_read_rdy),
    .i_ram_save_rdy   (ram_save_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM model: registered read, backdoor preload port ----------------
  logic [31:0] mem [0:32767];
  logic        bd_we;
  logic [14:0] bd_addr;
  logic [31:0] bd_dat;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_dat;
    else if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  // ---------------- scoreboard state ----------------
  logic [46:0] wq[$];   // expected writes {addr, data}
  logic        dq[$];   // expected err value at each done pulse
  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0, acc_cyc = 0, done_cyc = 0;
  int we_cnt = 0, rd_cnt = 0, done_cnt = 0, bnd_cnt = 0;
  int first_we = 0, last_we = 0;
  bit sb_on = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [46:0] e;
    cyc++;
    if (!rst) begin
      if (ram_we && ram_start_read) check("we_and_start_read", 64'(1), 64'(0));
      if (ram_we && !ram_save_rdy)  check("we_without_save_rdy", 64'(1), 64'(0));
      if (ram_we) begin
        if (we_cnt == 0) first_we = cyc;
        last_we = cyc;
        we_cnt++;
        if (sb_on) begin
          if (wq.size() == 0) begin
            check("unexpected_write", 64'(1), 64'(0));
          end else begin
            e = wq.pop_front();
            check("wr_addr", 64'(ram_addr), 64'(e[46:32]));
            check("wr_data", 64'(ram_din), 64'(e[31:0]));
          end
        end
      end
      if (ram_start_read) rd_cnt++;
      if (busy && !done) bnd_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (dq.size() == 0) check("unexpected_done", 64'(1), 64'(0));
        else check("done_err", 64'(err), 64'(dq.pop_front()));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic poke(input logic [14:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_dat = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic clr();
    we_cnt = 0; rd_cnt = 0; done_cnt = 0; bnd_cnt = 0; first_we = 0; last_we = 0;
  endtask

  task automatic issue(input logic op, input logic [14:0] s, input logic [14:0] d,
                       input logic [11:0] l, input logic [31:0] f);
    @(negedge clk);
    clr();
    cmd_op = op; cmd_src = s; cmd_dst = d; cmd_len = l; cmd_fill = f;
    cmd_valid = 1'b1;
    @(posedge clk);
    acc_cyc = cyc;
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk); #1;
      if (done) begin ok = 1'b1; break; end
    end
    check({name, "_done_seen"}, 64'(ok), 64'(1));
    @(negedge clk); #1;
    check({name, "_ready_after_done"}, 64'(cmd_ready), 64'(1));
    check({name, "_queues_drained"}, 64'(wq.size() + dq.size()), 64'(0));
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_src = '0; cmd_dst = '0;
    cmd_len = '0; cmd_fill = '0; ram_read_rdy = 1'b1; ram_save_rdy = 1'b1;
    bd_we = 1'b0; bd_addr = '0; bd_dat = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_we", 64'(ram_we), 64'(0));
    check("rst_start_read", 64'(ram_start_read), 64'(0));
    check("rst_addr", 64'(ram_addr), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // FILL 0x010..0x013, neighbours must survive
    poke(15'h00F, 32'h1111_1111);
    poke(15'h014, 32'h2222_2222);
    for (int i = 0; i < 4; i++) wq.push_back({15'(15'h010 + i), 32'hDEAD_BEEF});
    dq.push_back(1'b0);
    issue(1'b1, 15'h000, 15'h010, 12'd4, 32'hDEAD_BEEF);
    wait_done("fill");
    check("fill_we_cnt", 64'(we_cnt), 64'(4));
    check("fill_we_consecutive", 64'(last_we - first_we), 64'(3));
    check("fill_done_cnt", 64'(done_cnt), 64'(1));
    check("fill_mem_00f", 64'(mem[15'h00F]), 64'(32'h1111_1111));
    check("fill_mem_014", 64'(mem[15'h014]), 64'(32'h2222_2222));
    check("fill_mem_013", 64'(mem[15'h013]), 64'(32'hDEAD_BEEF));

    // COPY 0x100..0x102 -> 0x200..0x202, with a cmd_valid pulse while busy
    poke(15'h100, 32'd1); poke(15'h101, 32'd2); poke(15'h102, 32'd3);
    wq.push_back({15'h200, 32'd1});
    wq.push_back({15'h201, 32'd2});
    wq.push_back({15'h202, 32'd3});
    dq.push_back(1'b0);
    issue(1'b0, 15'h100, 15'h200, 12'd3, 32'h0);
    repeat (2) @(negedge clk);
    cmd_op = 1'b1; cmd_dst = 15'h050; cmd_len = 12'd1; cmd_fill = 32'hBAD0_BAD0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done("copy");
    check("copy_phase_cycles", 64'(bnd_cnt - 1), 64'(9));
    check("copy_reads", 64'(rd_cnt), 64'(3));
    check("copy_writes", 64'(we_cnt), 64'(3));
    check("copy_busy_cmd_ignored", 64'(mem[15'h050]), 64'(mem[15'h051]));

    // Overlapping COPY must walk downward
    poke(15'h100, 32'hA); poke(15'h101, 32'hB); poke(15'h102, 32'hC); poke(15'h103, 32'hD);
    wq.push_back({15'h104, 32'hD});
    wq.push_back({15'h103, 32'hC});
    wq.push_back({15'h102, 32'hB});
    wq.push_back({15'h101, 32'hA});
    dq.push_back(1'b0);
    issue(1'b0, 15'h100, 15'h101, 12'd4, 32'h0);
    wait_done("ovl");
    check("ovl_mem_101", 64'(mem[15'h101]), 64'(32'hA));
    check("ovl_mem_104", 64'(mem[15'h104]), 64'(32'hD));
    check("ovl_mem_100", 64'(mem[15'h100]), 64'(32'hA));

    // Range error: 0xDFF + 2 > 0xE00
    dq.push_back(1'b1);
    issue(1'b1, 15'h000, 15'h0DFF, 12'd2, 32'h5555_5555);
    wait_done("range");
    check("range_we_cnt", 64'(we_cnt), 64'(0));
    check("range_err_sticky", 64'(err), 64'(1));

    // len=0 COPY: clears err, done two cycles after accept, no strobes
    dq.push_back(1'b0);
    issue(1'b0, 15'h100, 15'h200, 12'd0, 32'h0);
    wait_done("len0");
    check("len0_latency", 64'(done_cyc - acc_cyc), 64'(2));
    check("len0_strobes", 64'(we_cnt + rd_cnt), 64'(0));
    check("len0_err_clear", 64'(err), 64'(0));

    // FILL with 5 cycles of write backpressure
    for (int i = 0; i < 10; i++) wq.push_back({15'(15'h300 + i), 32'hC0FF_EE00});
    dq.push_back(1'b0);
    issue(1'b1, 15'h000, 15'h300, 12'd10, 32'hC0FF_EE00);
    repeat (3) @(negedge clk);
    ram_save_rdy = 1'b0;
    repeat (5) @(negedge clk);
    ram_save_rdy = 1'b1;
    wait_done("bp");
    check("bp_we_cnt", 64'(we_cnt), 64'(10));
    check("bp_latency", 64'(done_cyc - acc_cyc), 64'(17));
    check("bp_mem_309", 64'(mem[15'h309]), 64'(32'hC0FF_EE00));

    // Reset mid-COPY
    sb_on = 1'b0;
    issue(1'b0, 15'h400, 15'h500, 12'd8, 32'h0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_we", 64'(ram_we), 64'(0));
    check("midrst_start_read", 64'(ram_start_read), 64'(0));
    check("midrst_addr", 64'(ram_addr), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("midrst_no_done", 64'(done_cnt), 64'(0));
    check("midrst_idle", 64'(busy), 64'(0));
    sb_on = 1'b1;

    // Engine recovers after reset
    wq.push_back({15'h600, 32'h1234_5678});
    dq.push_back(1'b0);
    issue(1'b1, 15'h000, 15'h600, 12'd1, 32'h1234_5678);
    wait_done("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
